unidade_controle: RTL
=====================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: instr_valid  input  1  instruction word offered.
REQ-004 SHALL have port: instr_ready  output  1  high only in IDLE.
REQ-005 SHALL have port: instr  input  32  MIPS word: opcode [31:26], funct [5:0].
REQ-006 SHALL have port: zero_flag  input  1  ALU Zero_flag, sampled in EXEC.
REQ-007 SHALL have port: alu_op  output  5  ALU operation code; encoding per REQ-015.
REQ-008 SHALL have ports: alu_src_imm, reg_dst_rd, reg_write, mem_read, mem_write, mem_to_reg, jump, link, branch_taken  output  1 each  datapath controls.
REQ-009 SHALL have ports: busy  output  1  not IDLE; done  output  1  one-cycle retire pulse.
REQ-010 SHALL have port: state  output  3  current FSM state, for debug.

Function
REQ-011 SHALL implement FSM IDLE(0), DECODE(1), EXEC(2), MEM(3), WB(4), with every output registered.
REQ-012 SHALL latch instr and move IDLE->DECODE on a clock edge with instr_valid && instr_ready; instr is ignored in all other states.
REQ-013 SHALL go DECODE->EXEC always; from EXEC go to MEM for lw/sw, WB for R-type (except jr), I-type ALU ops, lui and jal, and IDLE for beq, bne, j and jr.
REQ-014 SHALL go MEM->WB for lw and MEM->IDLE for sw; WB->IDLE always.
REQ-015 SHALL drive alu_op from the latched word, valid from DECODE until back in IDLE:
- R-funct 0x24 AND 00000; 0x25 OR 00001; 0x20 ADD 00010; 0x26 XOR 00011; 0x27 NOR 00100.
- 0x2A SLT 00101; 0x22 SUB 00110; 0x2B SLTU 00111.
- 0x00 SLL 01000; 0x02 SRL 01001; 0x03 SRA 01010; 0x04 SLLV 01011; 0x06 SRLV 01100; 0x07 SRAV 01101; 0x08 JR 01110.
- opcode 0x08 ADDI 10000; 0x0C ANDI 10001; 0x0D ORI 10010; 0x0E XORI 10011; 0x04 BEQ 10100; 0x05 BNE 10101.
- 0x0A SLTI 10111; 0x0B SLTIU 11000; 0x0F LUI 11001; 0x23 LW 11010; 0x2B SW 11011.
- j, jal and anything unlisted: 01111.
REQ-016 SHALL assert alu_src_imm for I-type, reg_dst_rd for R-type, mem_read in MEM for lw only and mem_write in MEM for sw only.
REQ-017 SHALL assert reg_write only in WB, mem_to_reg in WB for lw only, and link in WB for jal only.
REQ-018 SHALL compute branch_taken = ~zero_flag in EXEC for beq/bne (the ALU returns 1 on a true compare), 0 otherwise.
REQ-019 SHALL assert jump in EXEC for j, jal and jr.
REQ-020 SHALL pulse done for exactly the last cycle before returning to IDLE.
REQ-021 Latency from accept edge to done cycle SHALL be 3 cycles (branch/jump), 4 (ALU ops, sw, jal) or 5 (lw).
REQ-022 SHALL treat R-type with an unlisted funct, or an unlisted opcode, as illegal: alu_op 01111, all write enables 0, path DECODE->EXEC->IDLE.

Reset
REQ-023 SHALL, on rst_n low at any time (mid-instruction included), immediately enter IDLE and drive all outputs 0 except instr_ready=1 and alu_op=01111.
REQ-024 SHALL discard any partially executed instruction on reset, without asserting mem_write or reg_write.

Configuration
REQ-025 With CTRL_ILLEGAL_TRAP_EN defined: SHALL add output illegal (1), set sticky on an illegal word in EXEC, cleared only by reset; while set, instr_ready SHALL stay 0.
REQ-026 Without CTRL_ILLEGAL_TRAP_EN: no illegal port; illegal words retire silently per REQ-022.

Structure
REQ-027 SHALL place FSM state encodings, ALU op codes, opcode and funct constants in shared package mips_pkg, also used by the ALU.
REQ-028 SHALL contain one combinational sub-module, dec_alu_op (instr in, alu_op/class out); the FSM stays in the top.

Verification
REQ-029 instr=0x00221820 (add) -> alu_op 00010, reg_dst_rd=1, reg_write=1 in WB, done 4 cycles after accept.
REQ-030 instr=0x8D280004 (lw) -> alu_op 11010, alu_src_imm=1, mem_read in MEM, mem_to_reg+reg_write in WB, done at 5 cycles.
REQ-031 instr=0x10220003 (beq), zero_flag=0 in EXEC -> branch_taken=1, reg_write never 1, done at 3 cycles; zero_flag=1 -> branch_taken=0.
REQ-032 instr=0xAD280000 (sw) with rst_n low during EXEC -> IDLE next, mem_write never asserted, instr_ready=1.
REQ-033 instr=0xFC000000 -> alu_op 01111, no enables; with CTRL_ILLEGAL_TRAP_EN, illegal=1 and instr_ready stays 0 until reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS control constants: FSM encodings, ALU op codes, opcode/funct fields.
// Used by the control unit and by the ALU.
package mips_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [4:0] ALU_AND   = 5'b00000;
  localparam logic [4:0] ALU_OR    = 5'b00001;
  localparam logic [4:0] ALU_ADD   = 5'b00010;
  localparam logic [4:0] ALU_XOR   = 5'b00011;
  localparam logic [4:0] ALU_NOR   = 5'b00100;
  localparam logic [4:0] ALU_SLT   = 5'b00101;
  localparam logic [4:0] ALU_SUB   = 5'b00110;
  localparam logic [4:0] ALU_SLTU  = 5'b00111;
  localparam logic [4:0] ALU_SLL   = 5'b01000;
  localparam logic [4:0] ALU_SRL   = 5'b01001;
  localparam logic [4:0] ALU_SRA   = 5'b01010;
  localparam logic [4:0] ALU_SLLV  = 5'b01011;
  localparam logic [4:0] ALU_SRLV  = 5'b01100;
  localparam logic [4:0] ALU_SRAV  = 5'b01101;
  localparam logic [4:0] ALU_JR    = 5'b01110;
  localparam logic [4:0] ALU_NOP   = 5'b01111;
  localparam logic [4:0] ALU_ADDI  = 5'b10000;
  localparam logic [4:0] ALU_ANDI  = 5'b10001;
  localparam logic [4:0] ALU_ORI   = 5'b10010;
  localparam logic [4:0] ALU_XORI  = 5'b10011;
  localparam logic [4:0] ALU_BEQ   = 5'b10100;
  localparam logic [4:0] ALU_BNE   = 5'b10101;
  localparam logic [4:0] ALU_SLTI  = 5'b10111;
  localparam logic [4:0] ALU_SLTIU = 5'b11000;
  localparam logic [4:0] ALU_LUI   = 5'b11001;
  localparam logic [4:0] ALU_LW    = 5'b11010;
  localparam logic [4:0] ALU_SW    = 5'b11011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic r_type;   // legal R-type (rd destination)
    logic imm;      // second ALU operand is the immediate
    logic lw;
    logic sw;
    logic branch;   // beq / bne
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } instr_class_t;

  // Instructions that retire straight out of EXEC without MEM or WB.
  function automatic logic ends_in_exec(instr_class_t c);
    return c.branch | c.j | c.jr | c.illegal;
  endfunction

endpackage

// File: rtl/dec_alu_op.sv
// Combinational decoder: MIPS word -> ALU op code and instruction class.
module dec_alu_op
  import mips_pkg::*;
(
  input  logic [31:0]  instr,
  output logic [4:0]   alu_op,
  output instr_class_t cls
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    alu_op = ALU_NOP;
    cls    = '0;
    case (opcode)
      OP_RTYPE: begin
        cls.r_type = 1'b1;
        case (funct)
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_ADD:   alu_op = ALU_ADD;
          F_XOR:   alu_op = ALU_XOR;
          F_NOR:   alu_op = ALU_NOR;
          F_SLT:   alu_op = ALU_SLT;
          F_SUB:   alu_op = ALU_SUB;
          F_SLTU:  alu_op = ALU_SLTU;
          F_SLL:   alu_op = ALU_SLL;
          F_SRL:   alu_op = ALU_SRL;
          F_SRA:   alu_op = ALU_SRA;
          F_SLLV:  alu_op = ALU_SLLV;
          F_SRLV:  alu_op = ALU_SRLV;
          F_SRAV:  alu_op = ALU_SRAV;
          F_JR: begin
            alu_op = ALU_JR;
            cls.jr = 1'b1;
          end
          default: begin
            cls.r_type  = 1'b0;
            cls.illegal = 1'b1;
          end
        endcase
      end
      OP_J:     cls.j   = 1'b1;
      OP_JAL:   cls.jal = 1'b1;
      OP_BEQ:   begin alu_op = ALU_BEQ;   cls.branch = 1'b1; end
      OP_BNE:   begin alu_op = ALU_BNE;   cls.branch = 1'b1; end
      OP_ADDI:  begin alu_op = ALU_ADDI;  cls.imm = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_ANDI;  cls.imm = 1'b1; end
      OP_ORI:   begin alu_op = ALU_ORI;   cls.imm = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XORI;  cls.imm = 1'b1; end
      OP_SLTI:  begin alu_op = ALU_SLTI;  cls.imm = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTIU; cls.imm = 1'b1; end
      OP_LUI:   begin alu_op = ALU_LUI;   cls.imm = 1'b1; end
      OP_LW:    begin alu_op = ALU_LW;    cls.imm = 1'b1; cls.lw = 1'b1; end
      OP_SW:    begin alu_op = ALU_SW;    cls.imm = 1'b1; cls.sw = 1'b1; end
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle MIPS control FSM (IDLE/DECODE/EXEC/MEM/WB) with registered outputs.
// Optional sticky illegal-instruction trap: define CTRL_ILLEGAL_TRAP_EN.
module unidade_controle
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        zero_flag,
  output logic [4:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_dst_rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        jump,
  output logic        link,
  output logic        branch_taken,
  output logic        busy,
  output logic        done,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic [2:0]  state
);

  logic [2:0]   state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [4:0]   alu_op_d;
  instr_class_t cls;
  logic         accept;
  logic         busy_d;
  logic         done_d;
  logic         exec_br_q;
  logic         ready_block;

  assign accept = instr_valid & instr_ready;
  // One decoder serves both the incoming word (accept edge) and the latched one,
  // so every output can be registered from the next state.
  assign instr_d = accept ? instr : instr_q;

  dec_alu_op u_dec (
    .instr  (instr_d),
    .alu_op (alu_op_d),
    .cls    (cls)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (cls.lw | cls.sw)    state_d = S_MEM;
        else if (ends_in_exec(cls)) state_d = S_IDLE;
        else                    state_d = S_WB;
      end
      S_MEM:    state_d = cls.lw ? S_WB : S_IDLE;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = ((state_d == S_EXEC) && ends_in_exec(cls)) ||
                  ((state_d == S_MEM) && cls.sw) ||
                  (state_d == S_WB);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;
  assign ill_d       = ill_q | ((state_d == S_EXEC) && cls.illegal);
  assign ready_block = ill_d;
  assign illegal     = ill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_q <= 1'b0;
    else        ill_q <= ill_d;
  end
`else
  assign ready_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      alu_op      <= ALU_NOP;
      alu_src_imm <= 1'b0;
      reg_dst_rd  <= 1'b0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      jump        <= 1'b0;
      link        <= 1'b0;
      exec_br_q   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      instr_ready <= (state_d == S_IDLE) && !ready_block;
      alu_op      <= busy_d ? alu_op_d : ALU_NOP;
      alu_src_imm <= busy_d && cls.imm;
      reg_dst_rd  <= busy_d && cls.r_type;
      reg_write   <= (state_d == S_WB);
      mem_read    <= (state_d == S_MEM) && cls.lw;
      mem_write   <= (state_d == S_MEM) && cls.sw;
      mem_to_reg  <= (state_d == S_WB) && cls.lw;
      jump        <= (state_d == S_EXEC) && (cls.j | cls.jal | cls.jr);
      link        <= (state_d == S_WB) && cls.jal;
      exec_br_q   <= (state_d == S_EXEC) && cls.branch;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // zero_flag only exists while EXEC is live, so it gates the registered qualifier.
  assign branch_taken = exec_br_q & ~zero_flag;
  assign state        = state_q;

endmodule
